btn_event: RTL
==============

BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 Parameter LONG_TICKS, default 20, SHALL set the number of ticks held before long_press; the legal range SHALL be 1..255.
REQ-002 Parameter REPEAT_TICKS, default 4, SHALL set the number of ticks between repeat pulses in the LONG state; the legal range SHALL be 1..255.
REQ-003 clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 tick  input  1  SHALL be a one-clk-wide enable marking each 50 ms period, synchronous to clk.
REQ-006 btn_val  input  1  SHALL be the debounced button level from the debouncer stage; it is treated as asynchronous to clk.
REQ-007 press  output  1  SHALL pulse for one clk cycle per new press.
REQ-008 release  output  1  SHALL pulse for one clk cycle when the button is let go.
REQ-009 long_press  output  1  SHALL pulse for one clk cycle when the hold reaches LONG_TICKS.
REQ-010 repeat  output  1  SHALL pulse for one clk cycle every REPEAT_TICKS ticks after long_press.
REQ-011 held  output  1  SHALL be high while the FSM is in any state other than IDLE.

Function
REQ-012 btn_val SHALL pass through a 2-flop synchronizer; its output is btn_s.
REQ-013 The FSM SHALL have the states IDLE, SHORT and LONG; the encoding is binary, 2 bits.
REQ-014 In IDLE with btn_s=1, the FSM SHALL go to SHORT, clear the counter and assert press.
REQ-015 press SHALL be visible after the 3rd rising clk edge at which btn_val is sampled high: 2 sync stages plus 1 registered output.
REQ-016 In SHORT, on tick with btn_s=1, the counter SHALL increment; when tick arrives with counter=LONG_TICKS-1, the FSM SHALL assert long_press, go to LONG and clear the counter.
REQ-017 In LONG, on tick with btn_s=1, the counter SHALL increment; when tick arrives with counter=REPEAT_TICKS-1, the block SHALL assert repeat and clear the counter, so the counter wraps.
REQ-018 In SHORT or LONG with btn_s=0, the FSM SHALL assert release, go to IDLE and clear the counter.
REQ-019 The counter SHALL be 8 bits wide, SHALL never exceed max(LONG_TICKS,REPEAT_TICKS)-1, and SHALL only advance on tick.
REQ-020 If tick coincides with btn_s=0, release SHALL win: no long_press or repeat in that cycle.
REQ-021 press and release SHALL never assert in the same cycle; a one-cycle btn_s high SHALL give press, then release on the next cycle.
REQ-022 At most one of press, release, long_press and repeat SHALL be high in any cycle.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.
REQ-024 tick held high for several cycles SHALL count once per cycle; the debounced source never does this, but the behaviour SHALL be deterministic.

Reset
REQ-025 On rst=1 at a clk edge: the state SHALL be IDLE, the counter 0, both sync flops 0, and press, release, long_press, repeat and held all 0.
REQ-026 Reset mid-hold SHALL NOT emit release; after rst deasserts with btn_val still high, a fresh press SHALL occur per REQ-015.
REQ-027 rst SHALL take priority over all other inputs.

Structure
REQ-028 Package btn_pkg SHALL hold the state encodings (IDLE=0, SHORT=1, LONG=2), the default LONG_TICKS and REPEAT_TICKS, and the counter width of 8.
REQ-029 The synchronizer SHALL be a separate sub-module sync2 (inputs clk, rst, d; output q), reusable by other camera-board inputs.
REQ-030 The expected size of btn_event plus sync2 is 120-250 RTL lines.

Verification (LONG_TICKS=20, REPEAT_TICKS=4, tick every 10 clk)
REQ-031 btn_val high for 50 clk -> press at edge 3 after the rise; release 3 edges after the fall; no long_press; held high for 50 clk.
REQ-032 btn_val high through 30 ticks -> long_press on the 20th tick; repeat on ticks 24 and 28; one release after the fall.
REQ-033 btn_val falls in the same cycle as the 20th tick reaches the FSM -> release only; long_press never asserts.
REQ-034 btn_val high for 1 clk -> press, then release on the next cycle; held high for exactly 1 cycle.
REQ-035 rst asserted at tick 10 of a hold, btn_val still high -> all outputs 0 and no release; a new press 3 edges after rst deasserts; long_press 20 ticks later.
REQ-036 A one-hot checker over press, release, long_press and repeat SHALL run in every scenario; any violation fails the test.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and defaults for the button event block
// Purpose: FSM state encoding, default tick counts and counter width.
// Ports: none (package).
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHORT = 2'd1,
      ST_LONG  = 2'd2
   } state_e;

   localparam int LONG_TICKS_DEF   = 20;
   localparam int REPEAT_TICKS_DEF = 4;
   localparam int CNT_W            = 8;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/btn_event_if.sv
// rtl/btn_event_if.sv - button event bundle between button logic and its consumer
// Purpose: groups tick/button inputs and the registered event pulses.
// Ports: none; modport master = event generator, slave = consumer/driver.
interface btn_event_if;

   logic tick_i;       // one-clk enable per 50 ms period
   logic btn_val_i;    // debounced button level, asynchronous to clk
   logic press_o;      // one-cycle pulse per new press
   logic release_o;    // one-cycle pulse when the button is let go
   logic long_press_o; // one-cycle pulse when the hold reaches LONG_TICKS
   logic repeat_o;     // one-cycle pulse every REPEAT_TICKS ticks after long press
   logic held_o;       // high while the button is considered held

   modport master (
      input  tick_i,
      input  btn_val_i,
      output press_o,
      output release_o,
      output long_press_o,
      output repeat_o,
      output held_o
   );

   modport slave (
      output tick_i,
      output btn_val_i,
      input  press_o,
      input  release_o,
      input  long_press_o,
      input  repeat_o,
      input  held_o
   );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous level
// Purpose: brings an asynchronous input into the clk domain.
// Ports: clk (clock), rst (sync active-high reset), d (async input),
//        q (synchronized output, two clk of latency).
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/btn_event.sv
// rtl/btn_event.sv - converts a debounced button level into press/release/long/repeat pulses
// Purpose: synchronizes btn_val, runs an IDLE/SHORT/LONG FSM counting ticks,
//          and emits registered one-cycle event pulses.
// Ports: clk (clock), rst (sync active-high reset),
//        bus (btn_event_if.master: tick_i, btn_val_i in; press_o, release_o,
//        long_press_o, repeat_o, held_o out).
module btn_event
   import btn_pkg::*;
#(
   parameter int LONG_TICKS   = LONG_TICKS_DEF,   // 1..255
   parameter int REPEAT_TICKS = REPEAT_TICKS_DEF  // 1..255
) (
   input  logic         clk,
   input  logic         rst,
   btn_event_if.master  bus
);

   localparam cnt_t LONG_LAST   = cnt_t'(LONG_TICKS - 1);
   localparam cnt_t REPEAT_LAST = cnt_t'(REPEAT_TICKS - 1);

   logic   btn_s;
   state_e state_q, state_d;
   cnt_t   cnt_q, cnt_d;
   logic   press_q, press_d;
   logic   release_q, release_d;
   logic   long_q, long_d;
   logic   repeat_q, repeat_d;
   logic   held_q, held_d;

   sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.btn_val_i),
      .q   (btn_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= held_d;
      end
   end

   // Button-low is tested before tick in each held state so a release
   // always wins over a coincident long_press/repeat.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (btn_s) begin
               state_d = ST_SHORT;
               cnt_d   = '0;
               press_d = 1'b1;
            end
         end
         ST_SHORT: begin
            if (!btn_s) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (bus.tick_i) begin
               if (cnt_q == LONG_LAST) begin
                  state_d = ST_LONG;
                  cnt_d   = '0;
                  long_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + cnt_t'(1);
               end
            end
         end
         ST_LONG: begin
            if (!btn_s) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (bus.tick_i) begin
               if (cnt_q == REPEAT_LAST) begin
                  cnt_d    = '0;
                  repeat_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + cnt_t'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // held follows the registered state, so derive it from the next state.
      held_d = (state_d != ST_IDLE);
   end

   assign bus.press_o      = press_q;
   assign bus.release_o    = release_q;
   assign bus.long_press_o = long_q;
   assign bus.repeat_o     = repeat_q;
   assign bus.held_o       = held_q;

endmodule
